// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO with a valid/ready write port feeding an LSB-first
// asynchronous serialiser that has its own baud timer.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [7:0]    wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic          ser_out,
   output logic          busy,
   output logic [CW-1:0] fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          r_nonEmpty;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic          r_serOut;

   state_t        w_stateNext;
   logic [TW-1:0] w_timerNext;
   logic [2:0]    w_bitIdxNext;
   logic [7:0]    w_shiftNext;
   logic          w_parityNext;
   logic          w_serNext;
   logic          w_push;
   logic          w_pop;
   logic          w_tick;
   logic [7:0]    w_headByte;

   assign wr_ready   = (r_count != CW'(FIFO_DEPTH));
   assign w_push     = wr_valid && wr_ready;
   assign w_headByte = r_mem[r_rdPtr];
   assign w_tick     = (r_timer == TW'(CLKS_PER_BIT - 1));
   assign ser_out    = r_serOut;
   assign busy       = (r_state != IDLE) || (r_count != '0);
   assign fifo_count = r_count;

   // FIFO pointers and occupancy; r_nonEmpty delays the idle start decision by one
   // cycle so a byte written into an empty FIFO reaches the line exactly two edges later
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_nonEmpty <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_nonEmpty <= (r_count != '0);
      end
   end

   // FIFO storage needs no reset: only slots covered by the pointers are ever read
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= wr_data;
      end
   end

   // Transmit state, bit timer, bit counter, shift register and the registered line
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_serOut <= 1'b1;
      end else begin
         r_state  <= w_stateNext;
         r_timer  <= w_timerNext;
         r_bitIdx <= w_bitIdxNext;
         r_shift  <= w_shiftNext;
         r_parity <= w_parityNext;
         r_serOut <= w_serNext;
      end
   end

   // Next-state logic; the next line level is chosen on each transition so that every
   // bit, start and stop included, is held for exactly CLKS_PER_BIT cycles
   always_comb begin
      w_stateNext  = r_state;
      w_timerNext  = r_timer;
      w_bitIdxNext = r_bitIdx;
      w_shiftNext  = r_shift;
      w_parityNext = r_parity;
      w_serNext    = r_serOut;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            w_timerNext  = '0;
            w_bitIdxNext = '0;
            w_serNext    = 1'b1;
            if (r_nonEmpty && (r_count != '0)) begin
               w_pop        = 1'b1;
               w_shiftNext  = w_headByte;
               w_parityNext = ^w_headByte;
               w_serNext    = 1'b0;
               w_stateNext  = START;
            end
         end
         START: begin
            if (w_tick) begin
               w_timerNext  = '0;
               w_bitIdxNext = '0;
               w_serNext    = r_shift[0];
               w_stateNext  = DATA;
            end else begin
               w_timerNext = r_timer + 1'b1;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_timerNext = '0;
               w_shiftNext = {1'b0, r_shift[7:1]};
               if (r_bitIdx == 3'd7) begin
                  w_bitIdxNext = '0;
                  if (PARITY_EN != 0) begin
                     w_serNext   = r_parity;
                     w_stateNext = PARITY;
                  end else begin
                     w_serNext   = 1'b1;
                     w_stateNext = STOP;
                  end
               end else begin
                  w_bitIdxNext = r_bitIdx + 1'b1;
                  w_serNext    = r_shift[1];
               end
            end else begin
               w_timerNext = r_timer + 1'b1;
            end
         end
         PARITY: begin
            if (w_tick) begin
               w_timerNext  = '0;
               w_bitIdxNext = '0;
               w_serNext    = 1'b1;
               w_stateNext  = STOP;
            end else begin
               w_timerNext = r_timer + 1'b1;
            end
         end
         STOP: begin
            if (w_tick) begin
               w_timerNext = '0;
               if (r_bitIdx == 3'(STOP_BITS - 1)) begin
                  w_bitIdxNext = '0;
                  if (r_count != '0) begin
                     w_pop        = 1'b1;
                     w_shiftNext  = w_headByte;
                     w_parityNext = ^w_headByte;
                     w_serNext    = 1'b0;
                     w_stateNext  = START;
                  end else begin
                     w_serNext   = 1'b1;
                     w_stateNext = IDLE;
                  end
               end else begin
                  w_bitIdxNext = r_bitIdx + 1'b1;
                  w_serNext    = 1'b1;
               end
            end else begin
               w_timerNext = r_timer + 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_serNext   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed, table-driven bench for the buffered UART transmitter.
// dutA runs 8N1, dutB runs even parity with two stop bits; both use 4 clocks per bit.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [11:0] frame;
      int         nbits;
   } vec_t;

   logic          clock = 1'b0;
   logic          rstA, rstB;
   logic [7:0]    dataA, dataB;
   logic          validA, validB;
   logic          readyA, readyB;
   logic          serA, serB;
   logic          busyA, busyB;
   logic [CW-1:0] countA, countB;

   int   checks = 0;
   int   errors = 0;
   int   held;
   vec_t tbl [19];

   // Free-running bench clock
   always #5 clock = ~clock;

   uart_tx_buffered #(
      .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .STOP_BITS(1)
   ) dutA (
      .CLK(clock), .RST(rstA), .wr_data(dataA), .wr_valid(validA), .wr_ready(readyA),
      .ser_out(serA), .busy(busyA), .fifo_count(countA)
   );

   uart_tx_buffered #(
      .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .STOP_BITS(2)
   ) dutB (
      .CLK(clock), .RST(rstB), .wr_data(dataB), .wr_valid(validB), .wr_ready(readyB),
      .ser_out(serB), .busy(busyB), .fifo_count(countB)
   );

   function automatic logic [11:0] frame8N1(input logic [7:0] d);
      return {3'b000, 1'b1, d, 1'b0};
   endfunction

   function automatic logic getLine(input int sel);
      return (sel == 0) ? serA : serB;
   endfunction

   function automatic logic getBusy(input int sel);
      return (sel == 0) ? busyA : busyB;
   endfunction

   function automatic logic getReady(input int sel);
      return (sel == 0) ? readyA : readyB;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
      end
   endtask

   // Called at a negedge; pushes one byte, waiting (bounded) while wr_ready is low.
   // Returns at the negedge after the push edge with wr_valid dropped.
   task automatic applyStimulus(input int sel, input logic [7:0] d, output int waited);
      waited = 0;
      if (sel == 0) begin
         dataA = d;
         validA = 1'b1;
      end else begin
         dataB = d;
         validB = 1'b1;
      end
      while (!getReady(sel) && waited < 400) begin
         @(negedge clock);
         waited++;
      end
      if (waited >= 400) begin
         checks++;
         errors++;
         $display("[TB] FAIL push %02h: wr_ready stayed 0 for %0d cycles, wanted 1", d, waited);
      end
      @(posedge clock);
      @(negedge clock);
      validA = 1'b0;
      validB = 1'b0;
   endtask

   // Waits (bounded) for the start bit; returns at the first negedge with the line low
   task automatic waitFall(input int sel, input string name);
      int n;
      n = 0;
      while (getLine(sel) !== 1'b0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: start bit not seen, line %0b, wanted 0", name, getLine(sel));
      end
   endtask

   // Starting on the first cycle of a start bit, checks every cycle of one table frame
   task automatic checkFrame(input int row);
      vec_t v;
      logic lineOk;
      logic busyOk;
      logic seen;
      v = tbl[row];
      busyOk = 1'b1;
      for (int b = 0; b < v.nbits; b++) begin
         lineOk = 1'b1;
         seen = v.frame[b];
         for (int c = 0; c < CPB; c++) begin
            if (getLine(v.sel) !== v.frame[b]) begin
               lineOk = 1'b0;
               seen = getLine(v.sel);
            end
            if (getBusy(v.sel) !== 1'b1) busyOk = 1'b0;
            @(negedge clock);
         end
         checks++;
         if (!lineOk) begin
            errors++;
            $display("[TB] FAIL frame row %0d byte %02h bit %0d: line %0b, wanted %0b for %0d cycles",
                     row, v.data, b, seen, v.frame[b], CPB);
         end
      end
      checkOutput($sformatf("busy during frame row %0d", row), 32'(busyOk), 32'd1);
   endtask

   // Watchdog so a stuck DUT still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      tbl[0]  = '{0, 8'h55, frame8N1(8'h55), 10};
      tbl[1]  = '{1, 8'h07, 12'hE0E, 12};
      tbl[2]  = '{0, 8'hFF, frame8N1(8'hFF), 10};
      tbl[3]  = '{0, 8'hA1, frame8N1(8'hA1), 10};
      tbl[4]  = '{0, 8'hB2, frame8N1(8'hB2), 10};
      tbl[5]  = '{0, 8'hC3, frame8N1(8'hC3), 10};
      tbl[6]  = '{0, 8'hD4, frame8N1(8'hD4), 10};
      tbl[7]  = '{0, 8'hE5, frame8N1(8'hE5), 10};
      tbl[8]  = '{0, 8'h10, frame8N1(8'h10), 10};
      tbl[9]  = '{0, 8'h21, frame8N1(8'h21), 10};
      tbl[10] = '{0, 8'h32, frame8N1(8'h32), 10};
      tbl[11] = '{0, 8'h43, frame8N1(8'h43), 10};
      tbl[12] = '{0, 8'h54, frame8N1(8'h54), 10};
      tbl[13] = '{0, 8'h65, frame8N1(8'h65), 10};
      tbl[14] = '{0, 8'h76, frame8N1(8'h76), 10};
      tbl[15] = '{0, 8'h87, frame8N1(8'h87), 10};
      tbl[16] = '{0, 8'h98, frame8N1(8'h98), 10};
      tbl[17] = '{0, 8'hA9, frame8N1(8'hA9), 10};
      tbl[18] = '{0, 8'h81, frame8N1(8'h81), 10};

      // Reset held with the write port active: nothing may be queued or sent
      rstA = 1'b0;
      rstB = 1'b0;
      dataA = 8'hAA;
      dataB = 8'hAA;
      validA = 1'b1;
      validB = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checkOutput($sformatf("reset A line/busy/count/ready cycle %0d", i),
                     {serA, busyA, countA, readyA}, {1'b1, 1'b0, 3'd0, 1'b1});
         checkOutput($sformatf("reset B line/busy/count cycle %0d", i),
                     {serB, busyB, countB}, {1'b1, 1'b0, 3'd0});
      end
      validA = 1'b0;
      validB = 1'b0;
      rstA = 1'b1;
      rstB = 1'b1;
      @(negedge clock);
      checkOutput("count A after reset release", countA, 0);
      checkOutput("count B after reset release", countB, 0);

      // 8N1 frame of 0x55 with exact push-to-line latency
      applyStimulus(0, tbl[0].data, held);
      checkOutput("0x55 count after push", countA, 1);
      checkOutput("0x55 line one edge after push", serA, 1);
      @(negedge clock);
      checkOutput("0x55 line one edge later still idle", serA, 1);
      @(negedge clock);
      checkOutput("0x55 line falls two edges after push", serA, 0);
      checkFrame(0);
      checkOutput("0x55 busy after 40 line cycles", busyA, 0);
      checkOutput("0x55 line idle after frame", serA, 1);

      // Even parity, two stop bits: 48-cycle frame
      applyStimulus(1, tbl[1].data, held);
      @(negedge clock);
      checkOutput("0x07 line one edge later still idle", serB, 1);
      @(negedge clock);
      checkOutput("0x07 line falls two edges after push", serB, 0);
      checkFrame(1);
      checkOutput("0x07 busy after 48 cycles", busyB, 0);

      // Fill the FIFO during a frame; the fifth byte waits for the first pop
      applyStimulus(0, tbl[2].data, held);
      waitFall(0, "lead frame 0xFF");
      fork
         begin
            for (int r = 3; r <= 6; r++) applyStimulus(0, tbl[r].data, held);
            checkOutput("count at full", countA, 4);
            checkOutput("wr_ready at full", readyA, 0);
            applyStimulus(0, tbl[7].data, held);
            checkOutput("0xE5 hold-off cycles until first pop", held, 36);
         end
         begin
            for (int r = 2; r <= 7; r++) checkFrame(r);
         end
      join
      checkOutput("busy after back-to-back frames", busyA, 0);
      checkOutput("count after back-to-back frames", countA, 0);

      // Simultaneous push and pop at count 2, ten bytes through a depth-4 FIFO
      applyStimulus(0, tbl[8].data, held);
      waitFall(0, "wrap frame 0x10");
      fork
         begin
            applyStimulus(0, tbl[9].data, held);
            applyStimulus(0, tbl[10].data, held);
            repeat (37) @(negedge clock);
            checkOutput("count before push+pop", countA, 2);
            dataA = tbl[11].data;
            validA = 1'b1;
            @(posedge clock);
            @(negedge clock);
            validA = 1'b0;
            checkOutput("count after push+pop same cycle", countA, 2);
            for (int r = 12; r <= 17; r++) applyStimulus(0, tbl[r].data, held);
         end
         begin
            for (int r = 8; r <= 17; r++) checkFrame(r);
         end
      join
      checkOutput("count after wrap run", countA, 0);

      // Reset in mid-frame with bytes queued, then a clean frame afterwards
      applyStimulus(0, 8'h3C, held);
      waitFall(0, "frame 0x3C");
      applyStimulus(0, 8'h11, held);
      applyStimulus(0, 8'h22, held);
      repeat (4) @(negedge clock);
      checkOutput("0x3C data bit 0 on line", serA, 0);
      checkOutput("queued before mid-frame reset", countA, 2);
      #2;
      rstA = 1'b0;
      #1;
      checkOutput("line high at once on reset", serA, 1);
      checkOutput("count cleared at once on reset", countA, 0);
      checkOutput("busy cleared at once on reset", busyA, 0);
      checkOutput("ready at once on reset", readyA, 1);
      @(negedge clock);
      rstA = 1'b1;
      @(negedge clock);
      checkOutput("line idle after mid-frame reset", serA, 1);
      applyStimulus(0, tbl[18].data, held);
      waitFall(0, "frame 0x81");
      checkFrame(18);
      begin
         logic quiet;
         quiet = 1'b1;
         for (int i = 0; i < 40; i++) begin
            if (serA !== 1'b1 || busyA !== 1'b0) quiet = 1'b0;
            @(negedge clock);
         end
         checkOutput("no stale frame after reset", quiet, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
